// File: rtl/intra_chroma_sad_sched.sv
// intra_chroma_sad_sched
// Accumulates per-mode SADs (vertical, horizontal, DC) over the eight residual
// rows of one 8x8 chroma block, then picks the cheapest mode.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start, busy          block request (honoured only in IDLE) / not-idle flag
//   row_valid, row_ready residual row handshake (ready only while accumulating)
//   vrow, hrow, dcrow    eight signed 8-bit residuals per mode, sample k at [8k+7:8k]
//   out_valid, out_ready result handshake; results held until accepted
//   sad_v, sad_h, sad_dc per-mode SADs (live while accumulating)
//   best_mode, best_sad  winning mode (DC=0, H=1, V=2) and its SAD
module intra_chroma_sad_sched #(
  parameter int unsigned SAD_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [63:0]      vrow,
  input  logic [63:0]      hrow,
  input  logic [63:0]      dcrow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAD_W-1:0] sad_v,
  output logic [SAD_W-1:0] sad_h,
  output logic [SAD_W-1:0] sad_dc,
  output logic [1:0]       best_mode,
  output logic [SAD_W-1:0] best_sad
);

  // One row sums at most 8 * 128 = 1024, which needs 11 bits.
  localparam int unsigned ROW_W = 11;
  // Headroom of one bit over the wider operand so the saturation test is exact.
  localparam int unsigned EXT_W = ((SAD_W > ROW_W) ? SAD_W : ROW_W) + 1;
  localparam logic [EXT_W-1:0] SAT_MAX = EXT_W'((64'd1 << SAD_W) - 64'd1);

  localparam logic [1:0] MODE_DC = 2'd0;
  localparam logic [1:0] MODE_H  = 2'd1;
  localparam logic [1:0] MODE_V  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CMP   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [SAD_W-1:0] acc_v_q, acc_v_d;
  logic [SAD_W-1:0] acc_h_q, acc_h_d;
  logic [SAD_W-1:0] acc_dc_q, acc_dc_d;
  logic [1:0]       best_mode_q, best_mode_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;

  logic [ROW_W-1:0] rs_v, rs_h, rs_dc;

  // Sum of |sample| over one row; magnitude taken at 9 bits so |-128| = 128.
  function automatic logic [ROW_W-1:0] row_abs_sum(input logic [63:0] row);
    logic [ROW_W-1:0] s;
    logic [8:0]       ext;
    logic [8:0]       mag;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      ext = {row[8*k+7], row[8*k +: 8]};
      mag = ext[8] ? 9'(~ext + 9'd1) : ext;
      s   = s + ROW_W'(mag);
    end
    return s;
  endfunction

  // Saturating accumulate; sticks at the ceiling until cleared.
  function automatic logic [SAD_W-1:0] sat_add(input logic [SAD_W-1:0] acc,
                                               input logic [ROW_W-1:0] rs);
    logic [EXT_W-1:0] sum;
    sum = EXT_W'(acc) + EXT_W'(rs);
    return (sum > SAT_MAX) ? SAD_W'(SAT_MAX) : SAD_W'(sum);
  endfunction

  assign rs_v  = row_abs_sum(vrow);
  assign rs_h  = row_abs_sum(hrow);
  assign rs_dc = row_abs_sum(dcrow);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_v_q     <= '0;
      acc_h_q     <= '0;
      acc_dc_q    <= '0;
      best_mode_q <= MODE_DC;
      best_sad_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_v_q     <= acc_v_d;
      acc_h_q     <= acc_h_d;
      acc_dc_q    <= acc_dc_d;
      best_mode_q <= best_mode_d;
      best_sad_q  <= best_sad_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_v_d     = acc_v_q;
    acc_h_d     = acc_h_q;
    acc_dc_d    = acc_dc_q;
    best_mode_d = best_mode_q;
    best_sad_d  = best_sad_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          acc_v_d  = '0;
          acc_h_d  = '0;
          acc_dc_d = '0;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (row_valid) begin
          acc_v_d  = sat_add(acc_v_q, rs_v);
          acc_h_d  = sat_add(acc_h_q, rs_h);
          acc_dc_d = sat_add(acc_dc_q, rs_dc);
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ST_CMP;
          end
        end
      end
      ST_CMP: begin
        // DC wins ties against both; H wins ties against V only.
        if ((acc_dc_q <= acc_h_q) && (acc_dc_q <= acc_v_q)) begin
          best_mode_d = MODE_DC;
          best_sad_d  = acc_dc_q;
        end else if (acc_h_q <= acc_v_q) begin
          best_mode_d = MODE_H;
          best_sad_d  = acc_h_q;
        end else begin
          best_mode_d = MODE_V;
          best_sad_d  = acc_v_q;
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags decode straight from the state register.
  assign busy      = (state_q != ST_IDLE);
  assign row_ready = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUT);

  assign sad_v     = acc_v_q;
  assign sad_h     = acc_h_q;
  assign sad_dc    = acc_dc_q;
  assign best_mode = best_mode_q;
  assign best_sad  = best_sad_q;

endmodule

// File: tb/tb_intra_chroma_sad_sched.sv
// Bench for intra_chroma_sad_sched: two instances (SAD_W=14 and SAD_W=12)
// share one stimulus; expected results are queued as rows are driven and
// popped when out_valid appears.
module tb_intra_chroma_sad_sched;

  localparam int unsigned WA = 14;
  localparam int unsigned WB = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          row_valid;
  logic          out_ready;
  logic [63:0]   vrow, hrow, dcrow;

  logic          a_busy, a_row_ready, a_out_valid;
  logic [WA-1:0] a_sad_v, a_sad_h, a_sad_dc, a_best_sad;
  logic [1:0]    a_best_mode;
  logic          b_busy, b_row_ready, b_out_valid;
  logic [WB-1:0] b_sad_v, b_sad_h, b_sad_dc, b_best_sad;
  logic [1:0]    b_best_mode;

  typedef struct {
    int v;
    int h;
    int dc;
    int mode;
    int best;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  intra_chroma_sad_sched #(.SAD_W(WA)) u_a (
    .clk(clk), .reset(reset), .start(start), .busy(a_busy),
    .row_valid(row_valid), .row_ready(a_row_ready),
    .vrow(vrow), .hrow(hrow), .dcrow(dcrow),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .sad_v(a_sad_v), .sad_h(a_sad_h), .sad_dc(a_sad_dc),
    .best_mode(a_best_mode), .best_sad(a_best_sad)
  );

  intra_chroma_sad_sched #(.SAD_W(WB)) u_b (
    .clk(clk), .reset(reset), .start(start), .busy(b_busy),
    .row_valid(row_valid), .row_ready(b_row_ready),
    .vrow(vrow), .hrow(hrow), .dcrow(dcrow),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .sad_v(b_sad_v), .sad_h(b_sad_h), .sad_dc(b_sad_dc),
    .best_mode(b_best_mode), .best_sad(b_best_sad)
  );

  always #5 clk = ~clk;

  function automatic int row_sum(input logic [63:0] r);
    int s;
    int x;
    logic signed [7:0] b;
    s = 0;
    for (int k = 0; k < 8; k++) begin
      b = r[8*k +: 8];
      x = b;
      s += (x < 0) ? -x : x;
    end
    return s;
  endfunction

  function automatic int clampw(input int x, input int w);
    int m;
    m = (1 << w) - 1;
    return (x > m) ? m : x;
  endfunction

  function automatic exp_t make_exp(input int v, input int h, input int dc, input int w);
    exp_t e;
    e.v  = clampw(v, w);
    e.h  = clampw(h, w);
    e.dc = clampw(dc, w);
    if (e.dc <= e.h && e.dc <= e.v) begin
      e.mode = 0; e.best = e.dc;
    end else if (e.h < e.dc && e.h <= e.v) begin
      e.mode = 1; e.best = e.h;
    end else begin
      e.mode = 2; e.best = e.v;
    end
    return e;
  endfunction

  // Runs one block from IDLE; gap < 0 picks random gaps of 0..3 cycles.
  task automatic drive_block(input logic [7:0] vb, input logic [7:0] hb,
                             input logic [7:0] db, input bit rnd,
                             input int gap, input bit poke);
    int sv, sh, sd, gn;
    logic [63:0] rv, rh, rd;
    sv = 0; sh = 0; sd = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (a_row_ready !== 1'b1 || a_busy !== 1'b1 || b_row_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL start_latency: row_ready=%b/%b busy=%b, required 1", a_row_ready, b_row_ready, a_busy);
    end
    for (int r = 0; r < 8; r++) begin
      if (rnd) begin
        rv = {$urandom, $urandom}; rh = {$urandom, $urandom}; rd = {$urandom, $urandom};
      end else begin
        rv = {8{vb}}; rh = {8{hb}}; rd = {8{db}};
      end
      vrow = rv; hrow = rh; dcrow = rd; row_valid = 1'b1;
      @(negedge clk);
      row_valid = 1'b0;
      sv += row_sum(rv); sh += row_sum(rh); sd += row_sum(rd);
      n_cmp++;
      if (a_sad_v !== WA'(clampw(sv, WA)) || a_sad_h !== WA'(clampw(sh, WA)) ||
          a_sad_dc !== WA'(clampw(sd, WA)) || b_sad_v !== WB'(clampw(sv, WB)) ||
          b_sad_h !== WB'(clampw(sh, WB)) || b_sad_dc !== WB'(clampw(sd, WB))) begin
        n_bad++;
        $display("FAIL live_acc row%0d: a=%0d/%0d/%0d b=%0d/%0d/%0d, required raw %0d/%0d/%0d (clamped per width)",
                 r, a_sad_v, a_sad_h, a_sad_dc, b_sad_v, b_sad_h, b_sad_dc, sv, sh, sd);
      end
      if (r < 7) begin
        gn = (gap < 0) ? int'($urandom_range(3)) : gap;
        for (int g = 0; g < gn; g++) begin
          vrow = {$urandom, $urandom}; hrow = {$urandom, $urandom}; dcrow = {$urandom, $urandom};
          start = poke;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    q_a.push_back(make_exp(sv, sh, sd, WA));
    q_b.push_back(make_exp(sv, sh, sd, WB));
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b1 || a_row_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL cmp_cycle: out_valid=%b busy=%b row_ready=%b, required 0/1/0", a_out_valid, a_busy, a_row_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL out_latency: out_valid=%b/%b, required 1", a_out_valid, b_out_valid);
    end
  endtask

  // Waits for out_valid, stalls, checks held results, then completes the handshake.
  task automatic collect_result(input int stall, input bit poke, input string tag);
    int waited;
    exp_t ea, eb;
    waited = 0;
    out_ready = 1'b0;
    while (a_out_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (a_out_valid !== 1'b1 || q_a.size() == 0 || q_b.size() == 0) begin
      n_bad++;
      $display("FAIL %s timeout: out_valid=%b queued=%0d, required 1 and a pending result", tag, a_out_valid, q_a.size());
      return;
    end
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    for (int s = 0; s <= stall; s++) begin
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_sad_v !== WA'(ea.v) || a_sad_h !== WA'(ea.h) ||
          a_sad_dc !== WA'(ea.dc) || a_best_mode !== 2'(ea.mode) || a_best_sad !== WA'(ea.best)) begin
        n_bad++;
        $display("FAIL %s w14 cyc%0d: v=%0d h=%0d dc=%0d mode=%0d best=%0d valid=%b, required %0d/%0d/%0d/%0d/%0d valid=1",
                 tag, s, a_sad_v, a_sad_h, a_sad_dc, a_best_mode, a_best_sad, a_out_valid,
                 ea.v, ea.h, ea.dc, ea.mode, ea.best);
      end
      n_cmp++;
      if (b_out_valid !== 1'b1 || b_sad_v !== WB'(eb.v) || b_sad_h !== WB'(eb.h) ||
          b_sad_dc !== WB'(eb.dc) || b_best_mode !== 2'(eb.mode) || b_best_sad !== WB'(eb.best)) begin
        n_bad++;
        $display("FAIL %s w12 cyc%0d: v=%0d h=%0d dc=%0d mode=%0d best=%0d valid=%b, required %0d/%0d/%0d/%0d/%0d valid=1",
                 tag, s, b_sad_v, b_sad_h, b_sad_dc, b_best_mode, b_best_sad, b_out_valid,
                 eb.v, eb.h, eb.dc, eb.mode, eb.best);
      end
      if (s < stall) begin
        start = poke;
        @(negedge clk);
        start = 1'b0;
      end
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s handshake: out_valid=%b busy=%b, required 0/0", tag, a_out_valid, a_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0 || a_best_mode !== 2'(ea.mode) || a_best_sad !== WA'(ea.best)) begin
      n_bad++;
      $display("FAIL %s idle_hold: busy=%b mode=%0d best=%0d, required 0/%0d/%0d",
               tag, a_busy, a_best_mode, a_best_sad, ea.mode, ea.best);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; row_valid = 1'b0; out_ready = 1'b0;
    vrow = '0; hrow = '0; dcrow = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_busy, a_row_ready, a_out_valid, a_best_mode, a_best_sad, a_sad_v, a_sad_h, a_sad_dc} !== '0 ||
        {b_busy, b_row_ready, b_out_valid, b_best_mode, b_best_sad, b_sad_v, b_sad_h, b_sad_dc} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b ready=%b valid=%b mode=%0d best=%0d sads=%0d/%0d/%0d, required all 0",
               a_busy, a_row_ready, a_out_valid, a_best_mode, a_best_sad, a_sad_v, a_sad_h, a_sad_dc);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || b_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b out_valid=%b, required 0/0", a_busy, a_out_valid);
    end
  endtask

  task automatic test_zero();
    drive_block(8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    collect_result(0, 1'b0, "zero");
  endtask

  task automatic test_mixed();
    drive_block(8'h01, 8'hFE, 8'h03, 1'b0, 0, 1'b0);
    collect_result(0, 1'b0, "mixed");
  endtask

  task automatic test_extreme();
    drive_block(8'h80, 8'h7F, 8'h81, 1'b0, 0, 1'b0);
    collect_result(1, 1'b0, "extreme");
  endtask

  task automatic test_gaps_stall();
    drive_block(8'h01, 8'hFE, 8'h03, 1'b0, 2, 1'b1);
    collect_result(5, 1'b1, "gaps_stall");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive_block(8'h00, 8'h00, 8'h00, 1'b1, -1, 1'b1);
      collect_result(int'($urandom_range(2)), 1'b1, "random");
    end
  endtask

  task automatic test_reset_midblock();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      vrow = {8{8'h05}}; hrow = {8{8'h06}}; dcrow = {8{8'h07}}; row_valid = 1'b1;
      @(negedge clk);
    end
    row_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_busy, a_row_ready, a_out_valid, a_best_mode, a_best_sad, a_sad_v, a_sad_h, a_sad_dc} !== '0 ||
        {b_busy, b_row_ready, b_out_valid, b_best_mode, b_best_sad, b_sad_v, b_sad_h, b_sad_dc} !== '0) begin
      n_bad++;
      $display("FAIL midblock_reset: busy=%b ready=%b valid=%b mode=%0d best=%0d sads=%0d/%0d/%0d, required all 0",
               a_busy, a_row_ready, a_out_valid, a_best_mode, a_best_sad, a_sad_v, a_sad_h, a_sad_dc);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_quiet cyc%0d: out_valid=%b busy=%b, required 0/0", c, a_out_valid, a_busy);
      end
    end
    drive_block(8'h01, 8'hFE, 8'h03, 1'b0, 0, 1'b0);
    collect_result(0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_mixed();
    test_extreme();
    test_gaps_stall();
    test_back_to_back();
    test_reset_midblock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intra_chroma_sad_sched.md
INTRA_CHROMA_SAD_SCHED -- requirements
Module: intra_chroma_sad_sched

Interface
REQ-001 The block SHALL have parameter SAD_W, default 14, giving the width of each accumulated SAD (legal range 10..16).
REQ-002 clk  input  1  the single clock; every register SHALL be updated on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin one 8x8 chroma block.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 row_valid  input  1  an 8-sample residual row is present on vrow/hrow/dcrow.
REQ-007 row_ready  output  1  the block accepts a row this cycle.
REQ-008 vrow, hrow, dcrow  input  64 each  eight signed 8-bit residuals per mode (vertical, horizontal, DC); sample k is in bits [8k+7:8k].
REQ-009 out_valid  output  1  the result fields are valid.
REQ-010 out_ready  input  1  the consumer accepts the result.
REQ-011 sad_v, sad_h, sad_dc  output  SAD_W each  final per-mode SADs.
REQ-012 best_mode  output  2  winning mode code: DC=0, H=1, V=2; code 3 SHALL never be driven.
REQ-013 best_sad  output  SAD_W  the SAD of best_mode.

Function
REQ-014 The FSM SHALL have four states (IDLE, ACCUM, CMP, OUT), with a 3-bit row counter and three SAD_W accumulators.
REQ-015 IDLE: on start=1, clear the accumulators and row counter and go to ACCUM next cycle.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 row_ready SHALL be 1 exactly while in ACCUM, combinationally from state only.
REQ-018 A row SHALL be accepted on a cycle where row_valid and row_ready are both 1; rows are in raster order 0..7, and the row count is not checked against content.
REQ-019 Per accepted row, each accumulator SHALL add the sum of |sample| over its 8 samples; |x| is computed at 9 bits, so |-128| = 128.
REQ-020 Accumulation SHALL saturate at 2^SAD_W-1 and never wrap; once saturated, it stays there until cleared.
REQ-021 A cycle with row_valid=0 in ACCUM SHALL leave the accumulators and counter unchanged, so gaps of any length are allowed.
REQ-022 After the 8th row is accepted (counter wraps 7->0), the next state SHALL be CMP.
REQ-023 CMP SHALL last one cycle, compute the minimum SAD and register best_mode/best_sad, then go to OUT.
REQ-024 Tie-break priority SHALL be DC over H over V: a mode wins only if its SAD is strictly less than every higher-priority mode's SAD.
REQ-025 OUT: out_valid SHALL be 1, and all result outputs SHALL be held stable until out_ready=1.
REQ-026 out_valid and out_ready both 1 SHALL return the block to IDLE next cycle, with out_valid=0 that cycle.
REQ-027 A start in that same handshake cycle SHALL be ignored; a new block starts only from IDLE.
REQ-028 Latency SHALL be exact: start at cycle t gives row_ready from t+1.
REQ-029 With no gaps, the last row is accepted at t+8, CMP is at t+9, and out_valid first rises at t+10.
REQ-030 sad_v/sad_h/sad_dc SHALL show the live accumulators while in ACCUM; they are registered final values in CMP/OUT.
REQ-031 best_mode/best_sad SHALL keep their last values outside OUT, and SHALL be 0 after reset.

Reset
REQ-032 reset=1 SHALL immediately force state IDLE, with counter and accumulators 0.
REQ-033 During reset, busy, row_ready, out_valid, best_mode, best_sad, sad_v, sad_h and sad_dc SHALL all be 0.
REQ-034 Reset asserted mid-block (ACCUM, CMP or OUT) SHALL abandon that block without producing out_valid.
REQ-035 After reset deasserts, the block SHALL wait for a fresh start.

Verification
REQ-036 All residuals 0, no gaps, out_ready=1 -> out_valid at t+10 with sads 0/0/0 and best_mode=0 (DC, tie rule).
REQ-037 V rows all +1, H all -2, DC all +3 -> sad_v=64, sad_h=128, sad_dc=192; best_mode=2, best_sad=64.
REQ-038 V all -128, H all 127, DC all -127, SAD_W=14 -> 8192/8128/8128; best_mode=0 (DC beats H on tie).
REQ-039 The same stimulus with SAD_W=12 -> all three sads 4095; best_mode=0.
REQ-040 row_valid toggled 1,0,0,1,... and out_ready held 0 for 5 cycles -> sums as in REQ-037.
REQ-041 For REQ-040, out_valid and results SHALL stay stable during the stall, and start pulses while busy SHALL be ignored.
REQ-042 Reset pulsed after 4 rows accepted -> all outputs 0 at once, with no out_valid.
REQ-043 After REQ-042, a new start with the REQ-037 data SHALL give exactly REQ-037's results.
